// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers producer writes and issues one
// i_Tx_DV pulse per frame, pacing itself from the transmitter's Active/Done.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Wr_DV,
   input  logic [7:0]        i_Wr_Byte,
   output logic              o_Full,
   output logic              o_Empty,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Overflow,
   input  logic              i_Clr_Overflow,
   output logic              o_Tx_DV,
   output logic [7:0]        o_Tx_Byte,
   input  logic              i_Tx_Active,
   input  logic              i_Tx_Done
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_ACT  = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

   state_t            state_reg, state_next;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              full_reg, empty_reg, overflow_reg;
   logic              tx_dv_reg;
   logic [7:0]        tx_byte_reg;
   logic              wr_en, pop;

   // Full is the registered flag, so a write while full is dropped even if a
   // pop frees a slot on the same edge.
   assign wr_en = i_Wr_DV && !full_reg;

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty_reg && !i_Tx_Active) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:     state_next = WAIT_ACT;
         WAIT_ACT:  if (i_Tx_Active) state_next = WAIT_DONE;
         WAIT_DONE: if (i_Tx_Done)   state_next = GAP;
         GAP:       state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      case ({wr_en, pop})
         2'b10:   count_next = count_reg + ONE_COUNT;
         2'b01:   count_next = count_reg - ONE_COUNT;
         default: count_next = count_reg;
      endcase
   end

   // Storage array without reset so it maps onto RAM; read is registered into
   // tx_byte_reg on the pop.
   always_ff @(posedge i_Clock) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= i_Wr_Byte;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         overflow_reg <= 1'b0;
         tx_dv_reg    <= 1'b0;
         tx_byte_reg  <= 8'h00;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         full_reg  <= (count_next == FULL_COUNT);
         empty_reg <= (count_next == '0);
         tx_dv_reg <= pop;
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            tx_byte_reg <= mem[rd_ptr_reg];
         end
         if (i_Wr_DV && full_reg) begin
            overflow_reg <= 1'b1;
         end else if (i_Clr_Overflow) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign o_Full     = full_reg;
   assign o_Empty    = empty_reg;
   assign o_Count    = count_reg;
   assign o_Overflow = overflow_reg;
   assign o_Tx_DV    = tx_dv_reg;
   assign o_Tx_Byte  = tx_byte_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural transmitter stand-in, queue-based reference
// model and a per-cycle monitor; directed phases plus randomized streaming.
module tb_uart_tx_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int FRAME  = 40;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              wr_dv = 1'b0;
   logic [7:0]        wr_byte = 8'h00;
   logic              clr_ovf = 1'b0;
   logic              o_full, o_empty, o_overflow, o_tx_dv;
   logic [ADDR_W:0]   o_count;
   logic [7:0]        o_tx_byte;
   logic              tx_active, tx_done;

   logic              tx_busy = 1'b0;
   logic              tx_done_r = 1'b0;
   logic              force_active = 1'b0;
   int                tx_timer = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Wr_DV        (wr_dv),
      .i_Wr_Byte      (wr_byte),
      .o_Full         (o_full),
      .o_Empty        (o_empty),
      .o_Count        (o_count),
      .o_Overflow     (o_overflow),
      .i_Clr_Overflow (clr_ovf),
      .o_Tx_DV        (o_tx_dv),
      .o_Tx_Byte      (o_tx_byte),
      .i_Tx_Active    (tx_active),
      .i_Tx_Done      (tx_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Transmitter stand-in: busy for one frame after i_Tx_DV, then a one-cycle
   // Done as Active falls. It is not reset by the FIFO's reset.
   always @(posedge clk) begin
      tx_done_r <= 1'b0;
      if (!tx_busy) begin
         if (o_tx_dv) begin
            tx_busy  <= 1'b1;
            tx_timer <= 0;
         end
      end else if (tx_timer == FRAME - 1) begin
         tx_busy   <= 1'b0;
         tx_done_r <= 1'b1;
      end else begin
         tx_timer <= tx_timer + 1;
      end
   end
   assign tx_active = tx_busy | force_active;
   assign tx_done   = tx_done_r;

   // Reference model: queue of accepted bytes in write order, sticky flag.
   logic [7:0] mq[$];
   logic       ovf_m = 1'b0;
   bit         done_seen = 1'b1;
   int         idle_wait = 0;
   int         pulse_cnt = 0;
   int         sim_cnt = 0;
   int         n_pre;
   logic       wr_s, clr_s;
   logic [7:0] byte_s, exp_b;

   always @(posedge clk) begin
      wr_s   = wr_dv;
      byte_s = wr_byte;
      clr_s  = clr_ovf;
      n_pre  = mq.size();
      #1;
      if (!rst_n) begin
         mq.delete();
         ovf_m     = 1'b0;
         done_seen = 1'b1;
         idle_wait = 0;
         check("rst_tx_dv", o_tx_dv, 0);
         check("rst_count", o_count, 0);
         check("rst_empty", o_empty, 1);
         check("rst_overflow", o_overflow, 0);
      end else begin
         if (o_tx_dv) begin
            pulse_cnt++;
            idle_wait = 0;
            check("dv_link_free", {tx_active, tx_done}, 0);
            check("dv_after_done", done_seen, 1);
            check("dv_has_data", n_pre != 0, 1);
            if (mq.size() > 0) begin
               exp_b = mq.pop_front();
               check("tx_byte_order", o_tx_byte, exp_b);
               $display("tx issue byte 0x%02h (pending %0d)", o_tx_byte, mq.size());
            end
            done_seen = 1'b0;
            if (wr_s && n_pre < DEPTH) sim_cnt++;
         end
         if (wr_s && n_pre == DEPTH) ovf_m = 1'b1;
         else if (clr_s) ovf_m = 1'b0;
         if (wr_s && n_pre < DEPTH) mq.push_back(byte_s);
         if (tx_done) done_seen = 1'b1;
         check("count", o_count, mq.size());
         check("full", o_full, mq.size() == DEPTH);
         check("empty", o_empty, mq.size() == 0);
         check("overflow", o_overflow, ovf_m);
         if (mq.size() > 0 && !tx_active && !tx_done && !o_tx_dv) idle_wait++;
         else idle_wait = 0;
         if (idle_wait == 5) check("issue_stall_cycles", idle_wait, 0);
      end
   end

   task automatic drain(input string tag);
      int t = 0;
      while ((mq.size() != 0 || tx_busy || o_tx_dv) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(tag, t < 5000, 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int peak;
      int sent;
      int guard;
      int p0;

      #2 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_tx_dv", o_tx_dv, 0);
      check("reset_tx_byte", o_tx_byte, 8'h00);
      check("reset_empty", o_empty, 1);
      check("reset_full", o_full, 0);
      check("reset_count", o_count, 0);
      check("reset_overflow", o_overflow, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte and first-issue latency
      wr_dv = 1'b1; wr_byte = 8'hAB;
      @(posedge clk); #2;
      check("lat_no_dv_at_write_edge", o_tx_dv, 0);
      check("lat_count_after_write", o_count, 1);
      @(negedge clk); wr_dv = 1'b0;
      @(posedge clk); #2;
      check("lat_dv_next_edge", o_tx_dv, 1);
      check("lat_byte", o_tx_byte, 8'hAB);
      check("lat_count_after_pop", o_count, 0);
      @(posedge clk); #2;
      check("dv_one_cycle", o_tx_dv, 0);
      drain("single_drain");
      check("single_byte_held", o_tx_byte, 8'hAB);

      // Burst of five consecutive writes
      peak = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (int'(o_count) > peak) peak = int'(o_count);
         wr_dv = 1'b1; wr_byte = 8'(i);
      end
      @(negedge clk); wr_dv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (int'(o_count) > peak) peak = int'(o_count);
         @(negedge clk);
      end
      check("burst_peak_count", peak, 4);
      drain("burst_drain");

      // Overflow with the link held busy
      force_active = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i == 15) check("not_full_at_15", o_full, 0);
         if (i == 16) check("full_after_16", o_full, 1);
         wr_dv = 1'b1; wr_byte = 8'(8'h80 + i);
      end
      @(negedge clk); wr_dv = 1'b0;
      check("ovf_set", o_overflow, 1);
      check("ovf_count_16", o_count, 16);
      wr_dv = 1'b1; wr_byte = 8'hEE; clr_ovf = 1'b1;
      @(negedge clk); wr_dv = 1'b0; clr_ovf = 1'b0;
      check("ovf_set_beats_clear", o_overflow, 1);
      clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      check("ovf_cleared", o_overflow, 0);
      force_active = 1'b0;
      drain("ovf_drain");

      // Randomized stream, keeping the FIFO partially filled
      sent = 0;
      guard = 0;
      while (sent < 40 && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (mq.size() < 4 && $urandom_range(0, 1) == 1) begin
            wr_dv = 1'b1; wr_byte = 8'($urandom); sent++;
         end else begin
            wr_dv = 1'b0;
         end
      end
      @(negedge clk); wr_dv = 1'b0;
      check("stream_all_written", sent, 40);
      drain("stream_drain");
      $display("stream done, same-edge write+pop events %0d", sim_cnt);

      // Reset in the middle of a frame with bytes queued
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wr_dv = 1'b1; wr_byte = 8'(8'hC0 + i);
      end
      @(negedge clk); wr_dv = 1'b0;
      guard = 0;
      while (!tx_busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("midrst_frame_started", tx_busy, 1);
      repeat (10) @(negedge clk);
      check("midrst_queued", o_count, 3);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_count", o_count, 0);
      check("midrst_empty", o_empty, 1);
      check("midrst_tx_dv", o_tx_dv, 0);
      rst_n = 1'b1;
      p0 = pulse_cnt;
      repeat (100) @(negedge clk);
      check("midrst_no_dv", pulse_cnt - p0, 0);
      wr_dv = 1'b1; wr_byte = 8'h5A;
      @(negedge clk); wr_dv = 1'b0;
      drain("midrst_drain");
      check("midrst_new_byte_sent", pulse_cnt - p0, 1);
      check("midrst_new_byte", o_tx_byte, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
